// File: rtl/mem_data_in_unit.sv
// mem_data_in_unit: write-data source for S-type stores.
// Selects the register-file operand, an entry of a runtime-programmable
// constant table, or the next entry of a table-streaming sequence, and
// presents the result on a registered valid/ready output stage.
module mem_data_in_unit #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] ReadA,
  input  logic [SEL_W-1:0]  MemInputControl,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [DATA_W-1:0] DataMemIn,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  input  logic              ConstWe,
  input  logic [SEL_W-1:0]  ConstAddr,
  input  logic [DATA_W-1:0] ConstData,
  input  logic              SeqRestart
);

  localparam int NUM_CONST = 2 ** SEL_W;

  // Select codes and sequence pointer bounds.
  localparam logic [SEL_W-1:0] SEL_READA  = '0;
  localparam logic [SEL_W-1:0] SEL_SEQ    = '1;
  localparam logic [SEL_W-1:0] PTR_FIRST  = SEL_W'(1);
  localparam logic [SEL_W-1:0] PTR_SECOND = SEL_W'(2);
  localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(NUM_CONST - 2);

  // Power-on contents of the constant table. The 8-bit legacy constants
  // are zero-extended or truncated to DATA_W by the sized cast.
  function automatic logic [DATA_W-1:0] const_reset_value(input int idx);
    logic [7:0] v;
    case (idx)
      1:       v = 8'h20;
      2:       v = 8'h00;
      3:       v = 8'h40;
      4:       v = 8'hE1;
      5:       v = 8'hD4;
      6:       v = 8'hC6;
      7:       v = 8'hB8;
      8:       v = 8'hB4;
      9:       v = 8'hB2;
      10:      v = 8'hFA;
      11:      v = 8'hF3;
      default: v = 8'h00;
    endcase
    return DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] table_q [NUM_CONST];
  logic [SEL_W-1:0]  seq_ptr_q, seq_ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic              in_ready_s;
  logic              capture_s;
  logic              sel_seq_s;
  logic              tbl_we_s;
  logic              fwd_s;
  logic [SEL_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0] sel_val_s;

  // Address 0 aliases ReadA and the top address is the sequence code, so
  // neither is a writable table slot.
  assign tbl_we_s   = ConstWe && (ConstAddr != SEL_READA) && (ConstAddr != SEL_SEQ);
  assign in_ready_s = !valid_q || Out_Ready;
  assign capture_s  = In_Valid && in_ready_s;

  // Source selection: resolve the table index (restart overrides the
  // pointer in sequence mode) and forward a same-cycle table write.
  always_comb begin
    sel_seq_s = (MemInputControl == SEL_SEQ);
    if (sel_seq_s) begin
      if (SeqRestart) begin
        rd_idx_s = PTR_FIRST;
      end else begin
        rd_idx_s = seq_ptr_q;
      end
    end else begin
      rd_idx_s = MemInputControl;
    end
    fwd_s = tbl_we_s && (ConstAddr == rd_idx_s);
    if (MemInputControl == SEL_READA) begin
      sel_val_s = ReadA;
    end else if (fwd_s) begin
      sel_val_s = ConstData;
    end else begin
      sel_val_s = table_q[rd_idx_s];
    end
  end

  // Output stage next state: load on capture, drop valid once consumed,
  // otherwise hold (covers the stall case).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (capture_s) begin
      data_d  = sel_val_s;
      valid_d = 1'b1;
    end else if (Out_Ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Sequence pointer next state: restart wins; a restarting sequence
  // capture consumes entry 1 so the pointer moves on to entry 2.
  always_comb begin
    seq_ptr_d = seq_ptr_q;
    if (SeqRestart) begin
      if (capture_s && sel_seq_s) begin
        seq_ptr_d = PTR_SECOND;
      end else begin
        seq_ptr_d = PTR_FIRST;
      end
    end else if (capture_s && sel_seq_s) begin
      if (seq_ptr_q >= PTR_LAST) begin
        seq_ptr_d = PTR_FIRST;
      end else begin
        seq_ptr_d = seq_ptr_q + SEL_W'(1);
      end
    end else begin
      seq_ptr_d = seq_ptr_q;
    end
  end

  // Output register and sequence pointer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      seq_ptr_q <= PTR_FIRST;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      seq_ptr_q <= seq_ptr_d;
    end
  end

  // Constant table storage with power-on contents restored by reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CONST; i++) begin
        table_q[i] <= const_reset_value(i);
      end
    end else if (tbl_we_s) begin
      table_q[ConstAddr] <= ConstData;
    end else begin
      table_q[ConstAddr] <= table_q[ConstAddr];
    end
  end

  assign In_Ready  = in_ready_s;
  assign DataMemIn = data_q;
  assign Out_Valid = valid_q;

endmodule

// File: tb/tb_mem_data_in_unit.sv
// Directed bench for mem_data_in_unit with a transaction-level model
// checked every cycle plus hand-computed literal expectations.
module tb_mem_data_in_unit;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] ReadA = 8'h00;
  logic [3:0] MemInputControl = 4'd0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [7:0] DataMemIn;
  logic       Out_Valid;
  logic       Out_Ready = 1'b1;
  logic       ConstWe = 1'b0;
  logic [3:0] ConstAddr = 4'd0;
  logic [7:0] ConstData = 8'h00;
  logic       SeqRestart = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_data_in_unit #(.DATA_W(8), .SEL_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReadA(ReadA),
    .MemInputControl(MemInputControl), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .DataMemIn(DataMemIn), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .ConstWe(ConstWe), .ConstAddr(ConstAddr),
    .ConstData(ConstData), .SeqRestart(SeqRestart)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  int m_tbl [16];
  int m_ptr;
  int m_data;
  bit m_valid;

  task automatic model_reset();
    int init [16] = '{0, 32, 0, 64, 225, 212, 198, 184, 180, 178, 250, 243, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) m_tbl[i] = init[i];
    m_ptr   = 1;
    m_data  = 0;
    m_valid = 1'b0;
  endtask

  // Model advance: one transaction step per clock edge.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      model_reset();
    end else begin
      int  sel, entry, val;
      bit  take;
      int  view [16];
      sel = int'(MemInputControl);
      // table as seen by a capture this cycle: includes the write in flight
      for (int i = 0; i < 16; i++) view[i] = m_tbl[i];
      if (ConstWe && ConstAddr != 4'd0 && ConstAddr != 4'd15) view[ConstAddr] = int'(ConstData);
      take = In_Valid && (!m_valid || Out_Ready);
      if (sel == 15) entry = SeqRestart ? 1 : m_ptr;
      else entry = sel;
      val = (sel == 0) ? int'(ReadA) : view[entry];
      if (take) begin
        m_data  = val;
        m_valid = 1'b1;
      end else if (Out_Ready) begin
        m_valid = 1'b0;
      end
      if (take && sel == 15) m_ptr = (entry % 14) + 1;
      else if (SeqRestart) m_ptr = 1;
      for (int i = 0; i < 16; i++) m_tbl[i] = view[i];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (Reset_n) begin
      n_checks++;
      if (Out_Valid !== m_valid) begin
        n_fail++;
        $display("FAIL model_valid t=%0t got %0b want %0b", $time, Out_Valid, m_valid);
      end
      n_checks++;
      if (In_Ready !== (!m_valid || Out_Ready)) begin
        n_fail++;
        $display("FAIL model_ready t=%0t got %0b want %0b", $time, In_Ready, (!m_valid || Out_Ready));
      end
      if (m_valid) begin
        n_checks++;
        if (DataMemIn !== 8'(m_data)) begin
          n_fail++;
          $display("FAIL model_data t=%0t got %02h want %02h", $time, DataMemIn, 8'(m_data));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %02h want %02h", name, got, want);
    end
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input bit v, input logic [3:0] sel, input logic [7:0] ra,
                     input bit we, input logic [3:0] wa, input logic [7:0] wd,
                     input bit rs, input bit ordy);
    In_Valid = v; MemInputControl = sel; ReadA = ra;
    ConstWe = we; ConstAddr = wa; ConstData = wd;
    SeqRestart = rs; Out_Ready = ordy;
    @(posedge Clk);
    #1;
  endtask

  task automatic cap(input logic [3:0] sel, input logic [7:0] ra);
    cyc(1'b1, sel, ra, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
  endtask

  logic [7:0] seq_exp [15] = '{8'h20, 8'h00, 8'h77, 8'hE1, 8'h9C, 8'hC6, 8'hB8,
                               8'hB4, 8'hB2, 8'hFA, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h20};

  initial begin
    // 1. reset state and basic selection
    #2;
    chk("reset_valid", {7'd0, Out_Valid}, 8'h00);
    chk("reset_data", DataMemIn, 8'h00);
    chk("reset_ready", {7'd0, In_Ready}, 8'h01);
    @(posedge Clk); @(posedge Clk); #2;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    cap(4'd0, 8'h5A);  chk("sel0", DataMemIn, 8'h5A);
    chk("sel0_valid", {7'd0, Out_Valid}, 8'h01);
    cap(4'd4, 8'h00);  chk("sel4", DataMemIn, 8'hE1);
    cap(4'd11, 8'h00); chk("sel11", DataMemIn, 8'hF3);

    // 2. stall holds the output and blocks new captures
    cap(4'd0, 8'h11);  chk("stall_load", DataMemIn, 8'h11);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'd0, 8'h22, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      chk("stall_hold", DataMemIn, 8'h11);
      chk("stall_ready", {7'd0, In_Ready}, 8'h00);
    end
    cap(4'd0, 8'h22);  chk("stall_release", DataMemIn, 8'h22);
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    chk("idle_clear", {7'd0, Out_Valid}, 8'h00);

    // 3. table writes, including ignored addresses
    cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h9C, 1'b0, 1'b1);
    cap(4'd5, 8'h00);  chk("tbl_write5", DataMemIn, 8'h9C);
    cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'hFF, 1'b0, 1'b1);
    cap(4'd0, 8'h33);  chk("tbl_write0_ignored", DataMemIn, 8'h33);
    cap(4'd15, 8'h00); chk("tbl_write15_ignored", DataMemIn, 8'h20);

    // 4. same-cycle write forwarding
    cyc(1'b1, 4'd3, 8'h00, 1'b1, 4'd3, 8'h77, 1'b0, 1'b1);
    chk("forward", DataMemIn, 8'h77);

    // 5. sequence streaming with wrap, then restart priority
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cap(4'd15, 8'h00);
      chk($sformatf("seq_%0d", i), DataMemIn, seq_exp[i]);
    end
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cap(4'd15, 8'h00);
    chk("seq_pre_restart", DataMemIn, 8'h9C);
    cyc(1'b1, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    chk("seq_restart", DataMemIn, 8'h20);
    cyc(1'b1, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    chk("seq_after_restart", DataMemIn, 8'h00);
    cyc(1'b1, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    chk("seq_entry3", DataMemIn, 8'h77);

    // 6. asynchronous reset during a stall
    cap(4'd0, 8'h44);
    cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 8'h99, 1'b0, 1'b0);
    chk("pre_reset_hold", DataMemIn, 8'h44);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_valid", {7'd0, Out_Valid}, 8'h00);
    chk("async_data", DataMemIn, 8'h00);
    chk("async_ready", {7'd0, In_Ready}, 8'h01);
    ConstWe = 1'b0;
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    cap(4'd1, 8'h00);  chk("post_reset_tbl1", DataMemIn, 8'h20);
    cap(4'd15, 8'h00); chk("post_reset_seq", DataMemIn, 8'h20);
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    @(posedge Clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
